// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS core: sequences the shared datapath
// through fetch/decode/execute, decodes ALU operations and counts retired instructions.
module mips_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [5:0]       Op,
    input  logic [5:0]       Funct,
    input  logic             Zero,
    output logic             IorD,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUControl,
    output logic [1:0]       PCSrc,
    output logic             PCEn,
    output logic [3:0]       Stat,
    output logic [CNT_W-1:0] InstrCount
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMRD    = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWR    = 4'd5;
    localparam logic [3:0] S_EXECUTE  = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_ADDIEXEC = 4'd9;
    localparam logic [3:0] S_ADDIWB   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;
    logic             pc_write;
    logic             branch;
    logic [1:0]       alu_op;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_d = S_MEMWB;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ADDIEXEC: state_d = S_ADDIWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // Every terminal state returns to FETCH, so leaving one retires an instruction.
    always_comb begin
        case (state_q)
            S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: retire = 1'b1;
            default: retire = 1'b0;
        endcase
        cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_comb begin
        IorD     = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        PCSrc    = 2'b00;
        alu_op   = 2'b00;
        pc_write = 1'b0;
        branch   = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB  = 2'b01;
                IRWrite  = 1'b1;
                pc_write = 1'b1;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR, S_ADDIEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: IorD = 1'b1;
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                alu_op  = 2'b10;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                alu_op  = 2'b01;
                PCSrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_JUMP: begin
                PCSrc    = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (alu_op)
            2'b01: ALUControl = 3'b110;
            2'b10: begin
                case (Funct)
                    6'b100000: ALUControl = 3'b010;
                    6'b100010: ALUControl = 3'b110;
                    6'b100100: ALUControl = 3'b000;
                    6'b100101: ALUControl = 3'b001;
                    6'b101010: ALUControl = 3'b111;
                    default:   ALUControl = 3'b010;
                endcase
            end
            default: ALUControl = 3'b010;
        endcase
    end

    assign PCEn       = pc_write | (branch & Zero);
    assign Stat       = state_q;
    assign InstrCount = cnt_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized self-checking bench for mips_multicycle_ctrl against an
// instruction-level model (state sequence per opcode plus per-state control table).
module tb_mips_multicycle_ctrl;

    localparam int CW = 4;

    logic          CLK;
    logic          Reset;
    logic [5:0]    Op;
    logic [5:0]    Funct;
    logic          Zero;
    logic          IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0]    ALUSrcB;
    logic [2:0]    ALUControl;
    logic [1:0]    PCSrc;
    logic          PCEn;
    logic [3:0]    Stat;
    logic [CW-1:0] InstrCount;

    int n_tests;
    int n_fail;
    int exp_cnt;
    int seq[$];

    mips_multicycle_ctrl #(.CNT_W(CW)) dut (
        .CLK(CLK), .Reset(Reset), .Op(Op), .Funct(Funct), .Zero(Zero),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .PCSrc(PCSrc), .PCEn(PCEn),
        .Stat(Stat), .InstrCount(InstrCount)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Field order: IorD MemWrite IRWrite RegDst MemtoReg RegWrite ALUSrcA ALUSrcB[1:0] PCSrc[1:0]
    function automatic logic [10:0] exp_ctl(input int s);
        case (s)
            0:       return 11'b0010000_01_00;
            1:       return 11'b0000000_11_00;
            2, 9:    return 11'b0000001_10_00;
            3:       return 11'b1000000_00_00;
            4:       return 11'b0000110_00_00;
            5:       return 11'b1100000_00_00;
            6:       return 11'b0000001_00_00;
            7:       return 11'b0001010_00_00;
            8:       return 11'b0000001_00_01;
            10:      return 11'b0000010_00_00;
            11:      return 11'b0000000_00_10;
            default: return 11'b0;
        endcase
    endfunction

    function automatic logic [2:0] exp_alu(input int s, input logic [5:0] fn);
        if (s == 8) return 3'b110;
        if (s != 6) return 3'b010;
        case (fn)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic logic exp_pcen(input int s, input logic z);
        if (s == 0 || s == 11) return 1'b1;
        if (s == 8) return z;
        return 1'b0;
    endfunction

    // Instruction-level model: the list of states an opcode visits from FETCH.
    task automatic fill_seq(input logic [5:0] op);
        seq = {0, 1};
        case (op)
            6'b100011: seq = {seq, 2, 3, 4};
            6'b101011: seq = {seq, 2, 5};
            6'b000000: seq = {seq, 6, 7};
            6'b000100: seq = {seq, 8};
            6'b001000: seq = {seq, 9, 10};
            6'b000010: seq = {seq, 11};
            default: ;
        endcase
    endtask

    task automatic check_outputs(input string tag, input int s);
        logic [10:0] got_ctl;
        got_ctl = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, PCSrc};
        check_eq($sformatf("%s stat", tag), 32'(Stat), 32'(s));
        check_eq($sformatf("%s ctl s%0d", tag, s), 32'(got_ctl), 32'(exp_ctl(s)));
        check_eq($sformatf("%s alu s%0d", tag, s), 32'(ALUControl), 32'(exp_alu(s, Funct)));
        check_eq($sformatf("%s pcen s%0d", tag, s), 32'(PCEn), 32'(exp_pcen(s, Zero)));
        check_eq($sformatf("%s cnt s%0d", tag, s), 32'(InstrCount), 32'(exp_cnt));
    endtask

    // zmode: 0/1 force Zero, 2 randomizes it each cycle. Called at posedge+1 in FETCH.
    task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                             input int zmode);
        Op    = op;
        Funct = fn;
        fill_seq(op);
        foreach (seq[i]) begin
            Zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            #1;
            check_outputs($sformatf("%s op=%b c%0d", tag, op, i), seq[i]);
            @(posedge CLK);
            #1;
        end
        if (seq.size() > 2) exp_cnt = (exp_cnt + 1) % (1 << CW);
        check_eq($sformatf("%s op=%b back-to-fetch", tag, op), 32'(Stat), 32'd0);
    endtask

    // Walk a lw into MEMRD, then abort it asynchronously between edges.
    task automatic reset_in_memrd(input string tag);
        Op    = 6'b100011;
        Funct = 6'($urandom);
        Zero  = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_eq($sformatf("%s in-memrd", tag), 32'(Stat), 32'd3);
        #1 Reset = 1'b0;
        #1;
        exp_cnt = 0;
        check_outputs($sformatf("%s async", tag), 0);
        @(negedge CLK);
        Reset = 1'b1;
        @(posedge CLK);
        #1;
        check_eq($sformatf("%s post-release", tag), 32'(Stat), 32'd1);
        @(posedge CLK);
        #1;
        check_eq($sformatf("%s aborted-lw-to-fetch", tag), 32'(Stat), 32'd2);
        repeat (3) @(posedge CLK);
        #1;
        exp_cnt = 1;
        check_eq($sformatf("%s fresh-lw-done", tag), 32'(Stat), 32'd0);
        check_eq($sformatf("%s fresh-lw-cnt", tag), 32'(InstrCount), 32'd1);
    endtask

    logic [5:0] ops[7]    = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                              6'b001000, 6'b000010, 6'b111111};
    logic [5:0] functs[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                              6'b101010, 6'b000000};

    initial begin
        n_tests = 0;
        n_fail  = 0;
        exp_cnt = 0;
        Reset   = 1'b0;
        Op      = 6'b100011;
        Funct   = 6'b000000;
        Zero    = 1'b1;
        #3;
        check_outputs("reset", 0);
        @(negedge CLK);
        Reset = 1'b1;
        @(posedge CLK);
        #1;
        check_eq("release-decode", 32'(Stat), 32'd1);
        @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);
        Reset = 1'b1;
        @(posedge CLK);
        #1;
        Op = 6'b100011;
        check_eq("realign-decode", 32'(Stat), 32'd1);
        repeat (4) @(posedge CLK);
        #1;
        exp_cnt = 1;
        check_eq("lw-first-cnt", 32'(InstrCount), 32'd1);

        run_instr("sw", 6'b101011, 6'b000000, 2);
        run_instr("or", 6'b000000, 6'b100101, 2);
        run_instr("beq-t", 6'b000100, 6'b000000, 1);
        run_instr("beq-nt", 6'b000100, 6'b000000, 0);
        run_instr("j", 6'b000010, 6'b000000, 2);
        run_instr("addi", 6'b001000, 6'b000000, 2);
        run_instr("illegal", 6'b111111, 6'b000000, 2);
        run_instr("r-badfn", 6'b000000, 6'b000000, 2);
        reset_in_memrd("mid-rst");

        for (int k = 0; k < 80; k++) begin
            logic [5:0] op;
            if ($urandom_range(0, 7) == 0) op = 6'($urandom);
            else op = ops[$urandom_range(0, 6)];
            run_instr($sformatf("rnd%0d", k), op,
                      ($urandom_range(0, 3) == 0) ? 6'($urandom) : functs[$urandom_range(0, 5)], 2);
            if (k == 40) reset_in_memrd("rnd-rst");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
